// File: rtl/alu_pkg.sv
// ALU operation codes, forwarding selects and ID/EX control bundle
// shared by the operand stage and its forwarding unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BLT  = 4'b1001;
    localparam logic [3:0] ALU_BGE  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_TRUE = 4'b1111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src;
        logic use_pc;
    } id_ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass selection for both EX sources; the youngest
// producer (EX/MEM) wins over MEM/WB, and x0 is never bypassed.
module forward_unit
    import alu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
    input  logic                      i_exm_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_exm_rd,
    input  logic                      i_wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
    output fwd_sel_e                  o_fwd_a,
    output fwd_sel_e                  o_fwd_b
);

    logic w_exm_ok;
    logic w_wb_ok;

    assign w_exm_ok = i_exm_reg_write && (i_exm_rd != '0);
    assign w_wb_ok  = i_wb_reg_write && (i_wb_rd != '0);

    always_comb begin
        o_fwd_a = FWD_REG;
        if (w_exm_ok && (i_exm_rd == i_rs1)) begin
            o_fwd_a = FWD_EXM;
        end else if (w_wb_ok && (i_wb_rd == i_rs1)) begin
            o_fwd_a = FWD_WB;
        end
    end

    always_comb begin
        o_fwd_b = FWD_REG;
        if (w_exm_ok && (i_exm_rd == i_rs2)) begin
            o_fwd_b = FWD_EXM;
        end else if (w_wb_ok && (i_wb_rd == i_rs2)) begin
            o_fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and
// EX/MEM, MEM/WB operand forwarding feeding the ALU.
module id_ex_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rd1,
    input  logic [DATA_WIDTH-1:0]     id_rd2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic                      id_alu_src,
    input  logic                      id_use_pc,
    input  logic [OPCODE_LENGTH-1:0]  id_operation,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_branch,
    input  logic                      flush,
    input  logic                      exm_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
    input  logic [DATA_WIDTH-1:0]     exm_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_branch,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_pc
);

    id_ex_ctrl_t               r_ctrl;
    logic [REG_ADDR_WIDTH-1:0] r_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_rd1;
    logic [DATA_WIDTH-1:0]     r_rd2;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [DATA_WIDTH-1:0]     r_pc;
    logic [OPCODE_LENGTH-1:0]  r_op;

    logic                  w_bubble;
    fwd_sel_e              w_sel_a;
    fwd_sel_e              w_sel_b;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;

    // Only the registered EX state feeds the hazard check, never flush.
    assign stall = id_valid
                 & r_ctrl.valid
                 & r_ctrl.mem_read
                 & (r_rd != '0)
                 & ((r_rd == id_rs1) | (r_rd == id_rs2));

    assign w_bubble = flush | stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_pc   <= '0;
            r_op   <= '0;
        end else if (w_bubble) begin
            r_ctrl <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_pc   <= '0;
            r_op   <= '0;
        end else begin
            r_ctrl <= '{
                valid:     id_valid,
                reg_write: id_reg_write,
                mem_read:  id_mem_read,
                mem_write: id_mem_write,
                branch:    id_branch,
                alu_src:   id_alu_src,
                use_pc:    id_use_pc
            };
            r_rs1  <= id_rs1;
            r_rs2  <= id_rs2;
            r_rd   <= id_rd;
            r_rd1  <= id_rd1;
            r_rd2  <= id_rd2;
            r_imm  <= id_imm;
            r_pc   <= id_pc;
            r_op   <= id_operation;
        end
    end

    forward_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd (
        .i_rs1          (r_rs1),
        .i_rs2          (r_rs2),
        .i_exm_reg_write(exm_reg_write),
        .i_exm_rd       (exm_rd),
        .i_wb_reg_write (wb_reg_write),
        .i_wb_rd        (wb_rd),
        .o_fwd_a        (w_sel_a),
        .o_fwd_b        (w_sel_b)
    );

    always_comb begin
        w_fwd_a = r_rd1;
        unique case (w_sel_a)
            FWD_EXM: w_fwd_a = exm_result;
            FWD_WB:  w_fwd_a = wb_result;
            default: w_fwd_a = r_rd1;
        endcase
    end

    always_comb begin
        w_fwd_b = r_rd2;
        unique case (w_sel_b)
            FWD_EXM: w_fwd_b = exm_result;
            FWD_WB:  w_fwd_b = wb_result;
            default: w_fwd_b = r_rd2;
        endcase
    end

    assign SrcA          = r_ctrl.use_pc  ? r_pc  : w_fwd_a;
    assign SrcB          = r_ctrl.alu_src ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign Operation     = r_op;
    assign ex_valid      = r_ctrl.valid;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_branch     = r_ctrl.branch;
    assign ex_rd         = r_rd;
    assign ex_pc         = r_pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage: each cycle the
// expected outputs are queued and a monitor compares them on negedge.
module tb_id_ex_operand_stage;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
    logic        id_alu_src, id_use_pc;
    logic [3:0]  id_operation;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        stall;
    logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic        ex_mem_write, ex_branch;
    logic [4:0]  ex_rd;

    int checks;
    int failures;

    typedef struct {
        logic        st;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] sd;
        logic        v;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    id_ex_operand_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_rd1       (id_rd1),
        .id_rd2       (id_rd2),
        .id_imm       (id_imm),
        .id_pc        (id_pc),
        .id_alu_src   (id_alu_src),
        .id_use_pc    (id_use_pc),
        .id_operation (id_operation),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_branch    (id_branch),
        .flush        (flush),
        .exm_reg_write(exm_reg_write),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .stall        (stall),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .Operation    (Operation),
        .ex_store_data(ex_store_data),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_branch    (ex_branch),
        .ex_rd        (ex_rd),
        .ex_pc        (ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=0x%0h want=0x%0h",
                     nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(stall), 32'(e.st));
                chk("SrcA", SrcA, e.a);
                chk("SrcB", SrcB, e.b);
                chk("Operation", 32'(Operation), 32'(e.op));
                chk("store_data", ex_store_data, e.sd);
                chk("ex_valid", 32'(ex_valid), 32'(e.v));
                chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
                chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
                chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
                chk("ex_branch", 32'(ex_branch), 32'(e.br));
                chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                chk("ex_pc", ex_pc, e.pc);
            end
        end
    end

    task automatic push(input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] sd, input logic v,
                        input logic rw, input logic mr, input logic mw,
                        input logic br, input logic [4:0] rd,
                        input logic [31:0] pc);
        exp_t e;
        e.st = st; e.a = a; e.b = b; e.op = op; e.sd = sd;
        e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br;
        e.rd = rd; e.pc = pc;
        q.push_back(e);
    endtask

    task automatic push_zero(input logic st);
        push(st, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic asrc, input logic upc,
                          input logic [3:0] op, input logic rw,
                          input logic mr, input logic mw, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc;
        id_alu_src = asrc; id_use_pc = upc; id_operation = op;
        id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_branch = br;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd,
                           input logic [31:0] eres, input logic ww,
                           input logic [4:0] wrd, input logic [31:0] wres);
        exm_reg_write = ew; exm_rd = erd; exm_result = eres;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        // release reset; nothing captured yet
        reset_n = 1'b1;
        set_id(1, 1, 0, 2, 32'h100, 0, 4, 32'h40, 1, 0, ALU_ADD, 1, 0, 0, 0);
        push_zero(0);
        tick();
        push(0, 32'h100, 4, 4'b0010, 0, 1, 1, 0, 0, 0, 2, 32'h40);
        tick();
        // asynchronous reset mid-stream, inputs still busy
        reset_n = 1'b0;
        set_fwd(1, 3, 32'h55, 1, 2, 32'h66);
        push_zero(0);
        tick();
        reset_n = 1'b1;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 6, 5, 0, 7, 32'h80, 1, 0, ALU_ADD, 1, 0, 0, 0);
        push_zero(0);
        tick();
        push(0, 5, 7, 4'b0010, 0, 1, 1, 0, 0, 0, 6, 32'h80);
        set_id(1, 3, 0, 7, 32'h33, 32'h44, 0, 32'h84, 0, 0, ALU_ADD, 1, 0, 0, 0);
        tick();
        set_fwd(1, 3, 32'h11, 1, 3, 32'h22);
        push(0, 32'h11, 32'h44, 4'b0010, 32'h44, 1, 1, 0, 0, 0, 7, 32'h84);
        tick();
        set_fwd(0, 3, 32'h11, 1, 3, 32'h22);
        push(0, 32'h22, 32'h44, 4'b0010, 32'h44, 1, 1, 0, 0, 0, 7, 32'h84);
        tick();
        set_fwd(1, 0, 32'h11, 1, 0, 32'h22);
        push(0, 32'h33, 32'h44, 4'b0010, 32'h44, 1, 1, 0, 0, 0, 7, 32'h84);
        set_id(1, 1, 0, 4, 32'h1000, 0, 32'h10, 32'h90, 1, 0, ALU_ADD, 1, 1, 0, 0);
        tick();
        // lw x4 in EX, dependent add in decode
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5, 4, 8, 32'h50, 32'h999, 0, 32'h94, 0, 0, ALU_ADD, 1, 0, 0, 0);
        push(1, 32'h1000, 32'h10, 4'b0010, 0, 1, 1, 1, 0, 0, 4, 32'h90);
        tick();
        set_fwd(1, 4, 32'h1010, 0, 0, 0);
        push_zero(0);
        tick();
        set_fwd(0, 0, 0, 1, 4, 32'hCAFE);
        push(0, 32'h50, 32'hCAFE, 4'b0010, 32'hCAFE, 1, 1, 0, 0, 0, 8, 32'h94);
        set_id(1, 0, 0, 9, 0, 0, 32'h20, 32'h98, 1, 0, ALU_ADD, 1, 1, 0, 0);
        tick();
        // flush together with a load-use stall
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 9, 0, 10, 1, 2, 0, 32'h9C, 0, 0, ALU_SUB, 1, 0, 0, 0);
        flush = 1'b1;
        push(1, 0, 32'h20, 4'b0010, 0, 1, 1, 1, 0, 0, 9, 32'h98);
        tick();
        flush = 1'b0;
        push_zero(0);
        set_id(1, 2, 5, 0, 32'h2000, 32'h1234, 8, 32'hA0, 1, 0, ALU_ADD, 0, 0, 1, 0);
        tick();
        // store data forwarded while SrcB takes the offset
        set_fwd(1, 5, 32'hDEAD, 0, 0, 0);
        push(0, 32'h2000, 8, 4'b0010, 32'hDEAD, 1, 0, 0, 1, 0, 0, 32'hA0);
        set_id(1, 1, 2, 0, 7, 7, 0, 32'hB0, 0, 0, ALU_BEQ, 0, 0, 0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        push_zero(0);
        set_id(1, 0, 0, 11, 0, 0, 32'h1000, 32'hB0, 1, 1, ALU_ADD, 1, 0, 0, 0);
        tick();
        push(0, 32'hB0, 32'h1000, 4'b0010, 0, 1, 1, 0, 0, 0, 11, 32'hB0);
        set_id(1, 1, 2, 0, 7, 7, 0, 32'hB4, 0, 0, ALU_BEQ, 0, 0, 0, 1);
        tick();
        set_fwd(1, 2, 32'h77, 1, 1, 32'h66);
        push(0, 32'h66, 32'h77, 4'b1000, 32'h77, 1, 0, 0, 0, 1, 0, 32'hB4);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);
        push_zero(0);
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the EX-stage ALU.
- Registers decoded instruction fields and controls, and detects load-use hazards.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU inputs SrcA, SrcB and Operation plus forwarded store data.
- Supports stall, bubble and flush so that every ALU input is valid and hazard-free.

Parameters:
- DATA_WIDTH, 32, datapath width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  REG_ADDR_WIDTH  source register indices.
- id_rd  in  REG_ADDR_WIDTH  destination index.
- id_rd1, id_rd2  in  DATA_WIDTH  register-file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_alu_src  in  1  1 selects immediate for SrcB.
- id_use_pc  in  1  1 selects PC for SrcA (AUIPC/JAL).
- id_operation  in  OPCODE_LENGTH  ALU operation code.
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  controls.
- flush  in  1  branch redirect, kill the instruction being captured.
- exm_reg_write  in  1  EX/MEM writes a register.
- exm_rd  in  REG_ADDR_WIDTH  EX/MEM destination index.
- exm_result  in  DATA_WIDTH  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB writes a register.
- wb_rd  in  REG_ADDR_WIDTH  MEM/WB destination index.
- wb_result  in  DATA_WIDTH  MEM/WB writeback data.
- stall  out  1  hold PC and IF/ID (load-use).
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  registered controls.
- ex_rd  out  REG_ADDR_WIDTH  destination index.
- ex_pc  out  DATA_WIDTH  registered PC.

Behaviour:
- Reset (async, reset_n=0): every ID/EX register clears to 0, so all outputs are 0.
  - The reset value of Operation, 4'b0000 (AND), is harmless because ex_valid=0.
  - Deassertion takes effect on the first rising clk after reset_n goes high.
- Hazard detect (combinational on decode inputs):
  - stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - stall is computed from registered EX state only; it never depends on flush.
- Register update at each posedge, in priority order:
  1. flush=1: load a bubble. All control bits and ex_valid go to 0; data fields are don't-care but are cleared to 0.
  2. Else stall=1: load a bubble. The decode instruction is re-presented next cycle because upstream holds.
  3. Else: capture all id_* fields; ex_valid = id_valid.
- Latency: 1 cycle from decode inputs to registered fields; forwarding and outputs are combinational from the registers.
- Forwarding, per source (rs1r/rs2r are the registered indices):
  - EX/MEM has priority: fwd = exm_result if exm_reg_write & exm_rd!=0 & exm_rd==rsXr.
  - Else MEM/WB: fwd = wb_result if wb_reg_write & wb_rd!=0 & wb_rd==rsXr.
  - Else the registered rd1/rd2.
  - x0 is never forwarded.
- Operand selection:
  - SrcA = use_pc ? pc_r : fwdA.
  - SrcB = alu_src ? imm_r : fwdB.
  - ex_store_data = fwdB always.
  - Operation = registered id_operation.
- Bubbles drive Operation=4'b0000 with all controls 0.
- Simultaneous flush and stall: flush wins and stall is still asserted. Upstream discards the held instruction on redirect.
- reset_n asserted mid-operation: the pipeline is emptied immediately and asynchronously.

Decomposition:
- alu_pkg holds the operation constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_XOR=0011, ALU_SLL=0100, ALU_SRL=0101, ALU_SUB=0110, ALU_SRA=0111, ALU_BEQ=1000, ALU_BLT=1001, ALU_BGE=1010, ALU_BNE=1011, ALU_SLT=1100, ALU_TRUE=1111.
- alu_pkg also holds the fwd_sel_e enum {FWD_REG, FWD_EXM, FWD_WB} and the id_ex_ctrl_t packed struct.
- One sub-module, forward_unit (combinational), produces fwd_sel_e for each source; it is instantiated once and handles both sources.

Test Plan:
- Reset: hold reset_n=0 mid-stream with nonzero inputs -> all outputs 0 immediately; after release, first capture appears one cycle later.
- Plain ADDI, inputs rd1=5, imm=7, alu_src=1, op=0010 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- EX/MEM vs MEM/WB priority: both write x3 (exm_result=0x11, wb_result=0x22), registered rs1=3 -> SrcA=0x11. With exm_reg_write=0 -> SrcA=0x22. With rd=0 on both -> SrcA = register value.
- Load-use: lw x4 in EX, decode add rs2=4 -> stall=1 for exactly 1 cycle; next cycle ex_valid=0 (bubble); following cycle add captured and SrcB=wb_result.
- Flush with stall: flush=1 while stall=1 -> ex_valid=0, controls 0, Operation=0000.
- Store forwarding: sw with alu_src=1, imm=8, rs2 matching exm_rd with exm_result=0xDEAD -> SrcB=8, ex_store_data=0xDEAD.
